rr_arbiter: RTL and testbench

- Parametrised round-robin arbiter with a registered one-hot grant and a grant/acknowledge handshake.
- Successor to the combinational fixed-priority first-one picker. It adds a rotating priority pointer so no requester starves, holds the grant until the consumer acknowledges it, and supports back-to-back grants.
- Sits in front of shared resources (bus masters, shared memory ports) wherever several requesters contend.

---
 rtl/rr_arbiter_pkg.sv | 23 ++
 rtl/rr_pick_first.sv | 32 +++
 rtl/rr_arbiter.sv | 108 ++++++++++
 tb/tb_rr_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // OR-reduction encoder; exact only for a zero or one-hot input.
    function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = idx | 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Combinational circular first-one picker: lowest set bit of req at or above
// start, wrapping past NUM_REQ-1 to 0. start must be below NUM_REQ.
module rr_pick_first
    import rr_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   first;
    logic [2*NUM_REQ-1:0] dbl_first;

    // Rotate start down to bit 0, isolate the lowest one, then rotate back.
    always_comb begin
        dbl_req   = {req, req};
        rot       = NUM_REQ'(dbl_req >> start);
        first     = rot & (~rot + ONE);
        dbl_first = {first, first};
        pick      = NUM_REQ'((dbl_first << start) >> NUM_REQ);
        found     = |req;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and grant/ack handshake.
// Optional macro RR_ARB_LOCK_EN adds the lock input for multi-transfer bursts.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               gnt_ack,
`ifdef RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_vld,
    output arb_state_e         dbg_state
);

    // Handshake: a grant is offered while gnt_vld=1 and is transferred on
    // every clock edge where gnt_vld=1 and gnt_ack=1; gnt/gnt_id are frozen
    // until then, and gnt_ack is ignored while gnt_vld=0.

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   id_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   base;
    logic [IDX_W-1:0]   start;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_id;
    logic               found;
    logic               locked;

    // In GRANT the search only matters on an ack, where ptr takes gnt_id.
    assign base    = (state == GRANT) ? gnt_id : ptr;
    assign start   = (base == LAST) ? '0 : base + IDX_W'(1);
    assign pick_id = IDX_W'(onehot_to_idx(64'(pick)));

`ifdef RR_ARB_LOCK_EN
    assign locked = lock[gnt_id] & req[gnt_id];
`else
    assign locked = 1'b0;
`endif

    rr_pick_first #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .start (start),
        .pick  (pick),
        .found (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= LAST;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= id_nxt;
            ptr    <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    id_nxt    = pick_id;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ack && !locked) begin
                    ptr_nxt = gnt_id;
                    if (found) begin
                        gnt_nxt = pick;
                        id_nxt  = pick_id;
                    end else begin
                        gnt_nxt   = '0;
                        id_nxt    = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                id_nxt    = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign gnt_vld   = |gnt;
    assign dbg_state = state;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (NUM_REQ=4); lock checks run when
// RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter;
    import rr_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       gnt_ack;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    arb_state_e dbg_state;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt_ack   (gnt_ack),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_vld   (gnt_vld),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid);
        logic       ev;
        arb_state_e es;
        ev = |eg;
        es = ev ? GRANT : IDLE;
        n_vec++;
        if (gnt !== eg || gnt_id !== eid || gnt_vld !== ev || dbg_state !== es) begin
            n_err++;
            $display("FAIL %s: got gnt=%b id=%0d vld=%b state=%0d, want gnt=%b id=%0d vld=%b state=%0d",
                     name, gnt, gnt_id, gnt_vld, dbg_state, eg, eid, ev, es);
        end
    endtask

    // Drive inputs, take one rising edge, settle past it.
    task automatic step(input logic [3:0] r, input logic a);
        req     = r;
        gnt_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        gnt_ack = 1'b0;
        lock    = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        req     = '0;
        gnt_ack = 1'b0;
        lock    = '0;
        rst_n   = 1'b0;
        #2;
        check("reset_values", 4'b0000, 2'd0);
        do_reset();
        check("post_reset_idle", 4'b0000, 2'd0);

        // first pick, then hold while req changes
        tbl.push_back('{4'b1010, 1'b0, 4'b0010, 2'd1});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'b1111, 1'b0, 4'b0010, 2'd1});
        // ack every cycle with everyone requesting
        tbl.push_back('{4'b1111, 1'b1, 4'b0100, 2'd2});
        tbl.push_back('{4'b1111, 1'b1, 4'b1000, 2'd3});
        tbl.push_back('{4'b1111, 1'b1, 4'b0001, 2'd0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0100, 2'd2});
        tbl.push_back('{4'b1111, 1'b1, 4'b1000, 2'd3});
        // wrap past requester 3, then acked requester loses priority
        tbl.push_back('{4'b1001, 1'b1, 4'b0001, 2'd0});
        tbl.push_back('{4'b1001, 1'b1, 4'b1000, 2'd3});
        // ack with no requests returns to idle; idle ack ignored
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2});
        // granted requester drops req: grant still held
        tbl.push_back('{4'b0000, 1'b0, 4'b0100, 2'd2});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].ack);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id);
        end

        // asynchronous reset mid-grant clears outputs before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 2'd0);
        req     = '0;
        gnt_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_idle", 4'b0000, 2'd0);

        // rotation from a fresh pointer starts at requester 0
        for (int i = 0; i < 5; i++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (i % 4);
            step(4'b1111, 1'b1);
            check($sformatf("rotate%0d", i), eg, 2'(i % 4));
        end

`ifdef RR_ARB_LOCK_EN
        do_reset();
        lock = 4'b0001;
        step(4'b0011, 1'b1);
        check("lock_first", 4'b0001, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 1'b1);
            check($sformatf("lock_hold%0d", i), 4'b0001, 2'd0);
        end
        lock = 4'b0000;
        step(4'b0011, 1'b1);
        check("lock_release", 4'b0010, 2'd1);
        // lock on a requester that is not granted has no effect
        lock = 4'b0100;
        step(4'b0011, 1'b1);
        check("lock_unmatched", 4'b0001, 2'd0);
        // lock without req on the granted requester is ignored
        lock = 4'b0001;
        step(4'b0010, 1'b1);
        check("lock_no_req", 4'b0010, 2'd1);
        lock = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
